shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 97 +++++++++
 tb/tb_shift_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial transmit and serial-to-parallel receive controller.
// It shifts one WIDTH-bit word out and one word in per transfer, using a valid/ready handshake on each side.
module shift_seq_ctrl #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          tx_d    = in_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // tx drains toward the output end while rx fills from the opposite end
        if (MSB_FIRST) begin
          tx_d = {tx_q[WIDTH-2:0], 1'b0};
          rx_d = {rx_q[WIDTH-2:0], ser_in};
        end else begin
          tx_d = {1'b0, tx_q[WIDTH-1:1]};
          rx_d = {ser_in, rx_q[WIDTH-1:1]};
        end
        // Counter holds on the final bit so it never wraps inside a word
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_en    = (state_q == SHIFT);
  assign ser_out   = (state_q == SHIFT) & tx_q[OUT_IDX];
  assign out_valid = (state_q == DONE);
  assign out_data  = rx_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl with three instances: 3-bit MSB-first, 3-bit LSB-first loopback, and 8-bit MSB-first loopback.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance m: WIDTH=3, MSB_FIRST=1, ser_in driven by the bench
  logic       iv_m, ir_m, so_m, se_m, si_m, ov_m, or_m, bz_m;
  logic [2:0] id_m, od_m;
  // Instance l: WIDTH=3, MSB_FIRST=0, loopback
  logic       iv_l, ir_l, so_l, se_l, ov_l, or_l, bz_l;
  logic [2:0] id_l, od_l;
  // Instance w: WIDTH=8, MSB_FIRST=1, loopback
  logic       iv_w, ir_w, so_w, se_w, ov_w, or_w, bz_w;
  logic [7:0] id_w, od_w;

  shift_seq_ctrl #(.WIDTH(3), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .reset(reset), .in_valid(iv_m), .in_ready(ir_m), .in_data(id_m),
    .ser_out(so_m), .ser_en(se_m), .ser_in(si_m), .out_valid(ov_m),
    .out_ready(or_m), .out_data(od_m), .busy(bz_m));

  shift_seq_ctrl #(.WIDTH(3), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .reset(reset), .in_valid(iv_l), .in_ready(ir_l), .in_data(id_l),
    .ser_out(so_l), .ser_en(se_l), .ser_in(so_l), .out_valid(ov_l),
    .out_ready(or_l), .out_data(od_l), .busy(bz_l));

  shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w (
    .clk(clk), .reset(reset), .in_valid(iv_w), .in_ready(ir_w), .in_data(id_w),
    .ser_out(so_w), .ser_en(se_w), .ser_in(so_w), .out_valid(ov_w),
    .out_ready(or_w), .out_data(od_w), .busy(bz_w));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_m_reset(input string tag);
    chk({tag, ".in_ready"},  16'(ir_m), 16'd1);
    chk({tag, ".ser_en"},    16'(se_m), 16'd0);
    chk({tag, ".ser_out"},   16'(so_m), 16'd0);
    chk({tag, ".out_valid"}, 16'(ov_m), 16'd0);
    chk({tag, ".out_data"},  16'(od_m), 16'd0);
    chk({tag, ".busy"},      16'(bz_m), 16'd0);
  endtask

  logic [2:0] exp_bits, si_bits;
  logic [7:0] exp_w;

  initial begin
    reset = 1'b1;
    iv_m = 1'b1; id_m = 3'b101; si_m = 1'b0; or_m = 1'b0;
    iv_l = 1'b0; id_l = 3'b000; or_l = 1'b0;
    iv_w = 1'b0; id_w = 8'h00; or_w = 1'b0;

    // Reset values; in_valid high during reset must not start a word
    #2;
    chk_m_reset("rst0");
    #10;
    reset = 1'b0;
    iv_m = 1'b0;
    chk_m_reset("rst_release");
    tick();
    chk("rst_after.busy", 16'(bz_m), 16'd0);

    // Explicit ser_in pattern, MSB first
    id_m = 3'b101; iv_m = 1'b1;
    tick();
    iv_m = 1'b0;
    exp_bits = 3'b101; si_bits = 3'b110;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1.ser_en%0d", i), 16'(se_m), 16'd1);
      chk($sformatf("t1.ser_out%0d", i), 16'(so_m), 16'(exp_bits[2-i]));
      chk($sformatf("t1.out_valid%0d", i), 16'(ov_m), 16'd0);
      si_m = si_bits[2-i];
      tick();
    end
    chk("t1.done.out_valid", 16'(ov_m), 16'd1);
    chk("t1.done.out_data", 16'(od_m), 16'b110);
    chk("t1.done.ser_en", 16'(se_m), 16'd0);
    chk("t1.done.ser_out", 16'(so_m), 16'd0);

    // Hold DONE with out_ready low while in_valid is high
    iv_m = 1'b1; id_m = 3'b010; or_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3.hold%0d.out_valid", i), 16'(ov_m), 16'd1);
      chk($sformatf("t3.hold%0d.out_data", i), 16'(od_m), 16'b110);
      chk($sformatf("t3.hold%0d.in_ready", i), 16'(ir_m), 16'd0);
      chk($sformatf("t3.hold%0d.busy", i), 16'(bz_m), 16'd1);
    end
    iv_m = 1'b0; or_m = 1'b1;
    tick();
    or_m = 1'b0;
    chk("t3.rel.out_valid", 16'(ov_m), 16'd0);
    chk("t3.rel.in_ready", 16'(ir_m), 16'd1);
    chk("t3.rel.busy", 16'(bz_m), 16'd0);
    chk("t3.rel.rx_kept", 16'(od_m), 16'b110);

    // LSB-first loopback
    id_l = 3'b011; iv_l = 1'b1;
    tick();
    iv_l = 1'b0;
    exp_bits = 3'b110;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2.ser_en%0d", i), 16'(se_l), 16'd1);
      chk($sformatf("t2.ser_out%0d", i), 16'(so_l), 16'(exp_bits[2-i]));
      tick();
    end
    chk("t2.out_valid", 16'(ov_l), 16'd1);
    chk("t2.out_data", 16'(od_l), 16'b011);
    or_l = 1'b1;
    tick();
    or_l = 1'b0;
    chk("t2.rel.out_valid", 16'(ov_l), 16'd0);

    // Asynchronous reset in the middle of the third shift cycle
    id_m = 3'b010; iv_m = 1'b1;
    tick();
    iv_m = 1'b0;
    tick();
    tick();
    chk("t4.pre.ser_en", 16'(se_m), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_m_reset("t4.rst");
    tick();
    chk("t4.rst_edge.out_valid", 16'(ov_m), 16'd0);
    chk("t4.rst_edge.busy", 16'(bz_m), 16'd0);
    #3;
    reset = 1'b0;
    id_m = 3'b111; iv_m = 1'b1;
    tick();
    iv_m = 1'b0;
    chk("t4.acc.busy", 16'(bz_m), 16'd1);
    chk("t4.acc.in_ready", 16'(ir_m), 16'd0);
    si_bits = 3'b011;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4.ser_out%0d", i), 16'(so_m), 16'd1);
      chk($sformatf("t4.out_valid%0d", i), 16'(ov_m), 16'd0);
      si_m = si_bits[2-i];
      tick();
    end
    chk("t4.out_valid", 16'(ov_m), 16'd1);
    chk("t4.out_data", 16'(od_m), 16'b011);
    or_m = 1'b1;
    tick();
    or_m = 1'b0;
    chk("t4.rel.in_ready", 16'(ir_m), 16'd1);

    // Back-to-back words with in_valid and out_ready held high
    si_m = 1'b0; iv_m = 1'b1; or_m = 1'b1; id_m = 3'b100;
    tick();
    id_m = 3'b111;
    exp_bits = 3'b100;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5.w0.ser_out%0d", i), 16'(so_m), 16'(exp_bits[2-i]));
      tick();
    end
    chk("t5.w0.out_valid", 16'(ov_m), 16'd1);
    chk("t5.w0.out_data", 16'(od_m), 16'b000);
    id_m = 3'b011;
    tick();
    chk("t5.idle.in_ready", 16'(ir_m), 16'd1);
    chk("t5.idle.busy", 16'(bz_m), 16'd0);
    tick();
    chk("t5.w1.busy", 16'(bz_m), 16'd1);
    id_m = 3'b000;
    exp_bits = 3'b011;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5.w1.ser_out%0d", i), 16'(so_m), 16'(exp_bits[2-i]));
      tick();
    end
    chk("t5.w1.out_valid", 16'(ov_m), 16'd1);
    iv_m = 1'b0;
    tick();
    or_m = 1'b0;
    chk("t5.end.in_ready", 16'(ir_m), 16'd1);

    // WIDTH=8 loopback
    id_w = 8'hA5; iv_w = 1'b1;
    tick();
    iv_w = 1'b0;
    exp_w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6.ser_en%0d", i), 16'(se_w), 16'd1);
      chk($sformatf("t6.ser_out%0d", i), 16'(so_w), 16'(exp_w[7-i]));
      tick();
    end
    chk("t6.ser_en_off", 16'(se_w), 16'd0);
    chk("t6.out_valid", 16'(ov_w), 16'd1);
    chk("t6.out_data", 16'(od_w), 16'h00A5);
    or_w = 1'b1;
    tick();
    or_w = 1'b0;
    chk("t6.rel.out_valid", 16'(ov_w), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
